// File: rtl/regfile_fifo_ctrl_if.sv
// Enqueue/dequeue valid-ready handshake between the FIFO sequencer and the datapath.
// master = surrounding datapath (producer + consumer), slave = the FIFO controller.
interface regfile_fifo_ctrl_if #(
  parameter int W = 4
);
  logic         enq_valid;
  logic         enq_ready;
  logic [W-1:0] enq_data;
  logic         deq_valid;
  logic         deq_ready;
  logic [W-1:0] deq_data;

  modport master (
    output enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data
  );

  modport slave (
    input  enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data
  );
endinterface

// File: rtl/regfile_fifo_ctrl.sv
// First-word-fall-through FIFO sequencer over the shared 16x4 register file
// (two combinational read ports, one write port that writes on every edge).
module regfile_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int W        = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  regfile_fifo_ctrl_if.slave    fifo,
  output logic [AW:0]           count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [AW-1:0]         rf_rads0,
  output logic [AW-1:0]         rf_rads1,
  input  logic [W-1:0]          rf_rdis0,
  input  logic [W-1:0]          rf_rdis1,
  output logic [AW-1:0]         rf_wads,
  output logic [W-1:0]          rf_wdata
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count_q;
  logic          enq_fire;
  logic          deq_fire;

  // Status flags decode purely from the count register, so they only move at edges.
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign count       = count_q;

  // NOTE: enq_ready deliberately ignores deq_ready; a full FIFO frees a slot only
  // after the dequeue edge, which keeps the consumer off the producer's timing path.
  assign fifo.enq_ready = ~full;
  assign fifo.deq_valid = ~empty;
  assign fifo.deq_data  = rf_rdis0;

  assign enq_fire = fifo.enq_valid & fifo.enq_ready;
  assign deq_fire = fifo.deq_valid & fifo.deq_ready;

  assign rf_rads0 = head;
  assign rf_rads1 = tail;
  assign rf_wads  = tail;

  // NOTE: the register file has no write enable, so idle cycles write the tail slot
  // back with its own value read through port 1; this passes through the register
  // file's storage and is not a combinational loop.
  assign rf_wdata = enq_fire ? fifo.enq_data : rf_rdis1;

  // NOTE: pointers and count are the only state; the register-file contents are
  // never reset because only slots between head and tail are ever presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) tail <= tail + AW'(1);
      if (deq_fire) head <= head + AW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_fifo_ctrl.sv
// Directed bench for regfile_fifo_ctrl with a behavioural 16x4 register file and
// a reference queue for the expected FIFO order and pointer positions.
module tb_regfile_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [3:0] rf_rads0;
  logic [3:0] rf_rads1;
  logic [3:0] rf_rdis0;
  logic [3:0] rf_rdis1;
  logic [3:0] rf_wads;
  logic [3:0] rf_wdata;

  regfile_fifo_ctrl_if #(.W(4)) fifo_if ();

  regfile_fifo_ctrl #(
    .DEPTH(16), .AW(4), .W(4), .AF_LEVEL(12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo       (fifo_if),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .rf_rads0   (rf_rads0),
    .rf_rads1   (rf_rads1),
    .rf_rdis0   (rf_rdis0),
    .rf_rdis1   (rf_rdis1),
    .rf_wads    (rf_wads),
    .rf_wdata   (rf_wdata)
  );

  // Shared register file: writes every rising edge, combinational reads.
  logic [3:0] mem [16];
  always @(posedge clk) mem[rf_wads] <= rf_wdata;
  assign rf_rdis0 = mem[rf_rads0];
  assign rf_rdis1 = mem[rf_rads1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] q [$];
  int         exp_head = 0;
  int         exp_tail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check every output against the model, clock, update model.
  task automatic cycle(input bit ev, input logic [3:0] d, input bit dr, input bit fl);
    int n;
    bit ef;
    bit df;
    fifo_if.enq_valid = ev;
    fifo_if.enq_data  = d;
    fifo_if.deq_ready = dr;
    flush             = fl;
    #1;
    n = q.size();
    check("count",       count,             n);
    check("empty",       empty,             n == 0);
    check("full",        full,              n == 16);
    check("almost_full", almost_full,       n >= 12);
    check("enq_ready",   fifo_if.enq_ready, n != 16);
    check("deq_valid",   fifo_if.deq_valid, n != 0);
    check("rf_rads0",    rf_rads0,          exp_head);
    check("rf_rads1",    rf_rads1,          exp_tail);
    check("rf_wads",     rf_wads,           exp_tail);
    if (n > 0) check("deq_data", fifo_if.deq_data, q[0]);
    ef = ev && (n < 16);
    df = dr && (n > 0);
    check("rf_wdata", rf_wdata, ef ? d : mem[exp_tail]);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      exp_head = 0;
      exp_tail = 0;
    end else begin
      if (df) begin
        void'(q.pop_front());
        exp_head = (exp_head + 1) % 16;
      end
      if (ef) begin
        q.push_back(d);
        exp_tail = (exp_tail + 1) % 16;
      end
    end
  endtask

  initial begin
    int enq_n;
    int budget;
    bit ev;
    bit dr;
    logic [3:0] d;

    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    rst               = 1'b0;
    flush             = 1'b0;
    fifo_if.enq_valid = 1'b0;
    fifo_if.enq_data  = 4'h0;
    fifo_if.deq_ready = 1'b0;

    // Reset values, checked while rst is held.
    #1 rst = 1'b1;
    #1;
    check("rst_count",     count,             0);
    check("rst_empty",     empty,             1);
    check("rst_full",      full,              0);
    check("rst_af",        almost_full,       0);
    check("rst_enq_ready", fifo_if.enq_ready, 1);
    check("rst_deq_valid", fifo_if.deq_valid, 0);
    check("rst_rads0",     rf_rads0,          0);
    check("rst_rads1",     rf_rads1,          0);
    check("rst_wads",      rf_wads,           0);
    check("rst_wdata",     rf_wdata,          mem[0]);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Enqueue 1..5 with no consumer, then drain in order.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    check("t1_count", count, 5);
    check("t1_head_data", fifo_if.deq_data, 1);
    for (int i = 1; i <= 5; i++) begin
      check("t1_out", fifo_if.deq_data, i);
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
    end
    check("t1_empty", empty, 1);

    // Fill with 0..15; almost_full from count 12; 17th word refused.
    for (int i = 0; i < 16; i++) begin
      check("t2_af_ramp", almost_full, i >= 12);
      cycle(1'b1, 4'(i), 1'b0, 1'b0);
    end
    check("t2_full",      full,              1);
    check("t2_enq_ready", fifo_if.enq_ready, 0);
    check("t2_count",     count,             16);
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    check("t2_17th_count", count, 16);
    check("t2_17th_head",  fifo_if.deq_data, 0);

    // Full with both sides active: only the dequeue fires first, then both.
    cycle(1'b1, 4'h7, 1'b1, 1'b0);
    check("t3_first_count", count, 15);
    check("t3_first_head",  fifo_if.deq_data, 1);
    cycle(1'b1, 4'h7, 1'b1, 1'b0);
    check("t3_both_count", count, 15);
    check("t3_both_head",  fifo_if.deq_data, 2);

    // 40 random words through with random handshakes; pointers wrap several times.
    enq_n  = 0;
    budget = 0;
    while (enq_n < 40 && budget < 2000) begin
      ev = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      d  = 4'($urandom_range(0, 15));
      if (ev && q.size() < 16) enq_n++;
      cycle(ev, d, dr, 1'b0);
      budget++;
    end
    check("rand_enq_budget", enq_n, 40);
    budget = 0;
    while (q.size() > 0 && budget < 100) begin
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      budget++;
    end
    check("rand_drain_empty", empty, 1);

    // Idle hold: 0xA in slot 3 survives ten rewrite cycles.
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check("idle_rads0", rf_rads0, 3);
    check("idle_head",  fifo_if.deq_data, 4'hA);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 4'h0, 1'b0, 1'b0);
      check("idle_mem3", mem[3], 4'hA);
      check("idle_data", fifo_if.deq_data, 4'hA);
    end

    // Flush at count 7 with a concurrent enqueue.
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 4), 1'b0, 1'b0);
    check("fl_count_before", count, 7);
    cycle(1'b1, 4'h5, 1'b0, 1'b1);
    check("fl_count", count, 0);
    check("fl_empty", empty, 1);
    check("fl_rads1", rf_rads1, 0);

    // Asynchronous reset mid-stream, observed before the next clock edge.
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 4'h4, 1'b0, 1'b0);
    fifo_if.enq_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_count",     count,             0);
    check("arst_empty",     empty,             1);
    check("arst_deq_valid", fifo_if.deq_valid, 0);
    check("arst_enq_ready", fifo_if.enq_ready, 1);
    check("arst_rads0",     rf_rads0,          0);
    check("arst_rads1",     rf_rads1,          0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_head = 0;
    exp_tail = 0;
    @(posedge clk);
    #1;
    cycle(1'b1, 4'h6, 1'b0, 1'b0);
    check("post_rst_count", count, 1);
    check("post_rst_data",  fifo_if.deq_data, 4'h6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
